rbe_tcdm_port_aligner: RTL and testbench

- Sits directly downstream of the RBE top wrapper's flattened TCDM master ports and upstream of the cluster HCI/TCDM interconnect.
- Turns the wrapper's lock-step wide access (one req, AND-ed gnt, AND-ed r_valid) into MP independently handshaked 32-bit ports.
- Holds each narrow request until that port is granted, and aligns out-of-step read responses in per-port FIFOs before returning one wide response.
- Without it, a partial grant or skewed r_valid across banks corrupts the wide transfer.

---
 rtl/rbe_tcdm_port_aligner.sv | 144 ++++++++++++++
 tb/tb_rbe_tcdm_port_aligner.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rbe_tcdm_port_aligner.sv
// Splits the RBE lock-step wide TCDM access into MP independently handshaked
// 32-bit ports and realigns skewed per-port read responses into one wide beat.
module rbe_tcdm_port_aligner #(
  parameter int unsigned MP    = 4,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              in_req,
  output logic              in_gnt,
  input  logic [AW-1:0]     in_add,
  input  logic              in_wen,
  input  logic [4*MP-1:0]   in_be,
  input  logic [32*MP-1:0]  in_data,
  output logic [32*MP-1:0]  in_r_data,
  output logic              in_r_valid,
  output logic [MP-1:0]     out_req,
  input  logic [MP-1:0]     out_gnt,
  output logic [MP*AW-1:0]  out_add,
  output logic [MP-1:0]     out_wen,
  output logic [MP*4-1:0]   out_be,
  output logic [MP*32-1:0]  out_data,
  input  logic [MP*32-1:0]  out_r_data,
  input  logic [MP-1:0]     out_r_valid,
  output logic              busy_o,
  output logic              err_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [MP-1:0] granted_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          err_q;

  logic          can_issue;
  logic          all_g;
  logic [MP-1:0] port_req;
  logic [MP-1:0] fifo_valid;
  logic [MP-1:0] err_set;
  logic          cnt_inc;
  logic          cnt_dec;

  // Reads need a free response slot; writes never consume a credit.
  assign can_issue = ~in_wen | (cnt_q < DEPTH_C);
  assign port_req  = {MP{in_req & can_issue}} & ~granted_q;
  assign all_g     = &(granted_q | (port_req & out_gnt));
  assign in_gnt    = in_req & can_issue & all_g;

  assign out_req    = port_req;
  assign out_wen    = {MP{in_wen}};
  assign out_be     = in_be;
  assign out_data   = in_data;
  assign in_r_valid = &fifo_valid;
  assign busy_o     = busy_q;
  assign err_o      = err_q;

  assign cnt_inc = in_gnt & in_wen;
  // A pop can be caused by stray pushes with no read outstanding; never underflow.
  assign cnt_dec = in_r_valid & (cnt_q != '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      granted_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else if (clear_i) begin
      granted_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (in_gnt) granted_q <= '0;
      else        granted_q <= granted_q | (port_req & out_gnt);

      case ({cnt_inc, cnt_dec})
        2'b10:   if (cnt_q < DEPTH_C) cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase

      busy_q <= in_req | (cnt_q != '0) | (|granted_q);
      err_q  <= err_q | (|err_set);
    end
  end

  for (genvar i = 0; i < MP; i++) begin : g_port
    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic [CW-1:0] fill_q;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;

    assign out_add[i*AW +: AW] = in_add + AW'(4 * i);

    assign empty = (fill_q == '0);
    assign full  = (fill_q == DEPTH_C);
    assign pop   = in_r_valid;
    // A full FIFO still accepts a push when it is popped in the same cycle.
    assign push  = out_r_valid[i] & (~full | pop);

    assign err_set[i]    = out_r_valid[i] & ((full & ~pop) | (empty & (cnt_q == '0)));
    assign fifo_valid[i] = ~empty;
    assign in_r_data[32*i +: 32] = mem[rptr_q];

    // NOTE: the data array carries no reset; validity lives in fill_q/pointers,
    // so stale contents are never presented as a response.
    always_ff @(posedge clk_i) begin
      if (push) mem[wptr_q] <= out_r_data[32*i +: 32];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        wptr_q <= '0;
        rptr_q <= '0;
        fill_q <= '0;
      end else if (clear_i) begin
        wptr_q <= '0;
        rptr_q <= '0;
        fill_q <= '0;
      end else begin
        if (push) wptr_q <= (wptr_q == LAST_PTR) ? '0 : wptr_q + 1'b1;
        if (pop)  rptr_q <= (rptr_q == LAST_PTR) ? '0 : rptr_q + 1'b1;
        case ({push, pop})
          2'b10:   fill_q <= fill_q + 1'b1;
          2'b01:   fill_q <= fill_q - 1'b1;
          default: fill_q <= fill_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rbe_tcdm_port_aligner.sv
// Directed bench for rbe_tcdm_port_aligner (MP=4, DEPTH=2, AW=32): grant
// tracking, address generation, response realignment, credits and errors.
module tb_rbe_tcdm_port_aligner;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          clear_i;
  logic          in_req;
  logic          in_gnt;
  logic [31:0]   in_add;
  logic          in_wen;
  logic [15:0]   in_be;
  logic [127:0]  in_data;
  logic [127:0]  in_r_data;
  logic          in_r_valid;
  logic [3:0]    out_req;
  logic [3:0]    out_gnt;
  logic [127:0]  out_add;
  logic [3:0]    out_wen;
  logic [15:0]   out_be;
  logic [127:0]  out_data;
  logic [127:0]  out_r_data;
  logic [3:0]    out_r_valid;
  logic          busy_o;
  logic          err_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  rbe_tcdm_port_aligner #(.MP(4), .DEPTH(2), .AW(32)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (clear_i),
    .in_req      (in_req),
    .in_gnt      (in_gnt),
    .in_add      (in_add),
    .in_wen      (in_wen),
    .in_be       (in_be),
    .in_data     (in_data),
    .in_r_data   (in_r_data),
    .in_r_valid  (in_r_valid),
    .out_req     (out_req),
    .out_gnt     (out_gnt),
    .out_add     (out_add),
    .out_wen     (out_wen),
    .out_be      (out_be),
    .out_data    (out_data),
    .out_r_data  (out_r_data),
    .out_r_valid (out_r_valid),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the active edge; checks follow 1ns later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; in_req = 1'b0; in_add = '0; in_wen = 1'b0;
    in_be = '0; in_data = '0; out_gnt = '0; out_r_data = '0; out_r_valid = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    #1;
    check("rst_out_req", out_req, 4'b0000);
    check("rst_in_gnt", in_gnt, 1'b0);
    check("rst_r_valid", in_r_valid, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_err", err_o, 1'b0);

    // Write, all ports granted together
    tick();
    in_req = 1'b1; in_add = 32'h0000_1000; in_wen = 1'b0; in_be = 16'hF0F1;
    in_data = 128'h4444_4444_3333_3333_2222_2222_1111_1111; out_gnt = 4'b1111;
    #1;
    check("wr_in_gnt", in_gnt, 1'b1);
    check("wr_out_req", out_req, 4'b1111);
    check("wr_out_add", out_add, {32'h0000_100C, 32'h0000_1008, 32'h0000_1004, 32'h0000_1000});
    check("wr_out_wen", out_wen, 4'b0000);
    check("wr_out_be", out_be, 16'hF0F1);
    check("wr_out_data", out_data, 128'h4444_4444_3333_3333_2222_2222_1111_1111);
    tick();
    in_req = 1'b0; out_gnt = 4'b0000;
    tick();
    check("wr_busy_idle", busy_o, 1'b0);

    // Staggered grants
    in_req = 1'b1; in_add = 32'h0000_2000; out_gnt = 4'b0001;
    #1;
    check("stag_req_c1", out_req, 4'b1111);
    check("stag_gnt_c1", in_gnt, 1'b0);
    tick();
    out_gnt = 4'b0100;
    #1;
    check("stag_req_c2", out_req, 4'b1110);
    check("stag_gnt_c2", in_gnt, 1'b0);
    tick();
    out_gnt = 4'b1010;
    #1;
    check("stag_req_c3", out_req, 4'b1010);
    check("stag_gnt_c3", in_gnt, 1'b1);
    tick();
    out_gnt = 4'b0000;
    #1;
    check("stag_mask_clr", out_req, 4'b1111);
    check("stag_gnt_c4", in_gnt, 1'b0);
    in_req = 1'b0;

    // Skewed read response: port 2 three cycles late
    tick();
    in_req = 1'b1; in_wen = 1'b1; in_add = 32'h0000_3000; out_gnt = 4'b1111;
    #1;
    check("skew_rd_gnt", in_gnt, 1'b1);
    tick();
    in_req = 1'b0; out_gnt = 4'b0000;
    out_r_valid = 4'b1011; out_r_data = {32'hA3, 32'h0, 32'hA1, 32'hA0};
    #1;
    check("skew_rv_c0", in_r_valid, 1'b0);
    tick();
    out_r_valid = 4'b0000;
    #1;
    check("skew_rv_c1", in_r_valid, 1'b0);
    tick();
    tick();
    out_r_valid = 4'b0100; out_r_data = {32'h0, 32'hA2, 32'h0, 32'h0};
    #1;
    check("skew_rv_c3", in_r_valid, 1'b0);
    tick();
    out_r_valid = 4'b0000;
    #1;
    check("skew_rv_pulse", in_r_valid, 1'b1);
    check("skew_r_data", in_r_data, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    tick();
    check("skew_rv_single", in_r_valid, 1'b0);
    tick();
    check("skew_busy_idle", busy_o, 1'b0);
    check("skew_err", err_o, 1'b0);

    // Credit limit: two reads fill DEPTH, a write still passes, third read waits
    in_req = 1'b1; in_wen = 1'b1; in_add = 32'h0000_4000; out_gnt = 4'b1111;
    #1;
    check("cr_rd1_gnt", in_gnt, 1'b1);
    tick();
    in_add = 32'h0000_4010;
    #1;
    check("cr_rd2_gnt", in_gnt, 1'b1);
    tick();
    in_wen = 1'b0; in_add = 32'h0000_5000;
    #1;
    check("cr_wr_gnt", in_gnt, 1'b1);
    check("cr_wr_req", out_req, 4'b1111);
    tick();
    in_wen = 1'b1; in_add = 32'h0000_4020;
    #1;
    check("cr_rd3_req_blk", out_req, 4'b0000);
    check("cr_rd3_gnt_blk", in_gnt, 1'b0);
    tick();
    out_r_valid = 4'b1111; out_r_data = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    #1;
    check("cr_rd3_blk_c2", in_gnt, 1'b0);
    tick();
    out_r_valid = 4'b0000;
    #1;
    check("cr_rv1", in_r_valid, 1'b1);
    check("cr_rdata1", in_r_data, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
    check("cr_rd3_blk_rv", in_gnt, 1'b0);
    tick();
    check("cr_rd3_req", out_req, 4'b1111);
    check("cr_rd3_gnt", in_gnt, 1'b1);
    tick();
    in_req = 1'b0; out_gnt = 4'b0000;
    out_r_valid = 4'b1111; out_r_data = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    tick();
    out_r_data = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    #1;
    check("cr_rv2", in_r_valid, 1'b1);
    check("cr_rdata2", in_r_data, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
    tick();
    out_r_valid = 4'b0000;
    #1;
    check("cr_rv3", in_r_valid, 1'b1);
    check("cr_rdata3", in_r_data, {32'hD3, 32'hD2, 32'hD1, 32'hD0});
    tick();
    check("cr_rv_done", in_r_valid, 1'b0);
    tick();
    check("cr_busy_idle", busy_o, 1'b0);
    check("cr_err", err_o, 1'b0);

    // Address wrap
    in_req = 1'b1; in_wen = 1'b0; in_add = 32'hFFFF_FFF8; out_gnt = 4'b0000;
    #1;
    check("wrap_add", out_add, {32'h0000_0004, 32'h0000_0000, 32'hFFFF_FFFC, 32'hFFFF_FFF8});
    tick();
    in_req = 1'b0;

    // Spurious response sets a sticky error; soft clear removes it
    tick();
    out_r_valid = 4'b0010;
    tick();
    out_r_valid = 4'b0000;
    #1;
    check("err_set", err_o, 1'b1);
    tick();
    check("err_sticky", err_o, 1'b1);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    #1;
    check("clear_err", err_o, 1'b0);
    check("clear_rv", in_r_valid, 1'b0);

    // Reset in the middle of a partially granted transfer
    out_r_valid = 4'b0010;
    tick();
    out_r_valid = 4'b0000;
    in_req = 1'b1; in_wen = 1'b0; in_add = 32'h0000_6000; out_gnt = 4'b0011;
    #1;
    check("mid_err_set", err_o, 1'b1);
    check("mid_gnt", in_gnt, 1'b0);
    tick();
    out_gnt = 4'b0000;
    #1;
    check("mid_mask", out_req, 4'b1100);
    rst_i = 1'b1; in_req = 1'b0;
    #1;
    check("mid_rst_req", out_req, 4'b0000);
    check("mid_rst_err", err_o, 1'b0);
    check("mid_rst_busy", busy_o, 1'b0);
    tick();
    rst_i = 1'b0;
    tick();
    check("post_rst_busy", busy_o, 1'b0);
    check("post_rst_err", err_o, 1'b0);
    out_r_valid = 4'b0001;
    tick();
    out_r_valid = 4'b0000;
    #1;
    check("post_rst_stray_err", err_o, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
